apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//  APB responder at the far end of the APB controller interface. Decodes its
//  own bit of the Pselx bus and serves single-beat reads and writes to a
//  bank of 32-bit registers. Returns Prdata, Pready and Pslverr to the
//  controller, with a programmable number of wait states.
//  Sits behind the AHB-to-APB bridge as one of up to three peripheral slots.
// PARAMETERS
//  SLAVE_ID     0            index of the Pselx bit decoded by this slave (0..2)
//  BASE_ADDR    32'h0000_0000 window base; Paddr[31:5] must match BASE_ADDR[31:5]
//  NUM_REGS     8            register count; Paddr[4:2] selects word, Paddr[1:0] ignored
//  WAIT_STATES  0            Pready-low access cycles inserted per transfer (0..15)
//  ID_VALUE     32'hA9B0_0001 constant returned by read-only reg NUM_REGS-1
// PORTS
//  Pclk      in   1   clock, all logic on rising edge
//  Preset    in   1   synchronous reset, active-high
//  Pselx     in   3   one-hot peripheral select; this slave uses Pselx[SLAVE_ID]
//  Penable   in   1   APB access-phase strobe
//  Pwrite    in   1   1 = write, 0 = read
//  Paddr     in   32  byte address
//  Pwdata    in   32  write data
//  Prdata    out  32  read data, registered
//  Pready    out  1   transfer-complete strobe
//  Pslverr   out  1   error response, qualified by Pready
// BEHAVIOUR
//  Reset: Preset=1 at a rising edge forces IDLE, cnt=0, all regs=0, Prdata=0,
//   Pready=0, Pslverr=0. Applies mid-transfer: the transfer is dropped, no write.
//  Definitions: sel = Pselx[SLAVE_ID]; setup = sel & !Penable;
//   hit = (Paddr[31:5]==BASE_ADDR[31:5]); idx = Paddr[4:2].
//   ro = (idx==NUM_REGS-1); err = !hit | (Pwrite & ro).
//  FSM states: IDLE, WAIT, READY. Pready = (state==READY).
//   Pslverr = READY & err_q, else 0.
//  IDLE: on an edge with setup, latch Pwrite, idx and err into *_q.
//   If the latched access is a read with !err, load Prdata = reg[idx]
//   (ID_VALUE when ro). Prdata is unchanged for writes and errored reads.
//   Next state: WAIT with cnt=WAIT_STATES-1 when WAIT_STATES>0, else READY.
//  WAIT: Pready=0. If !sel, go to IDLE (abort). If cnt==0, go to READY.
//   Otherwise decrement cnt. Gives exactly WAIT_STATES Pready-low access cycles.
//  READY: Pready=1 for one cycle. At the edge, if sel & Penable & Pwrite_q & !err_q:
//   reg[idx_q] <= Pwdata. Always go to IDLE.
//  Abort: if !sel during READY, go to IDLE with no commit.
//  Back-to-back: the cycle after READY is the next setup cycle; IDLE samples it,
//   so zero-wait throughput is one transfer per 2 cycles.
//  Write to ro register or an address miss: Pslverr=1 with Pready, no state change.
//   Prdata is held.
//  Setup seen while Penable=1 in IDLE (protocol error): ignored, stay IDLE.
//  Pselx bits other than SLAVE_ID never affect this block.
//  Prdata is held between transfers. It is only meaningful when Pready=1.
// TESTING
//  Reset: Preset=1 for 2 cycles -> Prdata=0, Pready=0, Pslverr=0; read idx 0 -> 0.
//  WAIT_STATES=0: write 32'hDEAD_BEEF to BASE+0x8, then read BASE+0x8
//   -> Pready high in the 1st access cycle; Prdata=32'hDEAD_BEEF; Pslverr=0.
//  WAIT_STATES=3: read BASE+0x1C -> 3 Pready-low cycles, then Pready=1
//   with Prdata=ID_VALUE.
//  Write 32'h1 to BASE+0x1C (ro) -> Pslverr=1 with Pready; readback still ID_VALUE.
//  Read BASE+0x40 (miss) -> Pslverr=1.
//  Pselx=3'b010 with SLAVE_ID=0 -> Pready stays 0; no register changes.
//  Drop sel mid-WAIT on a write of 32'h55 to idx 2 -> returns to IDLE; idx 2 unchanged.
//  Repeat with Preset pulsed mid-WAIT -> all regs read 0.

Source files
------------

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the controller and one register-file responder.
interface apb_slave_regfile_if;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;
   logic        Pready;
   logic        Pslverr;

   modport master (
      output Pselx, Penable, Pwrite, Paddr, Pwdata,
      input  Prdata, Pready, Pslverr
   );

   modport slave (
      input  Pselx, Penable, Pwrite, Paddr, Pwdata,
      output Prdata, Pready, Pslverr
   );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB register-file responder: single-beat reads/writes to a small bank of
// 32-bit registers, top register is a read-only ID, programmable wait states.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | waiting for a setup cycle on our Pselx bit
//  ST_WAIT  | access phase, Pready low, counting down inserted wait cycles
//  ST_READY | Pready high for one cycle; writes commit at the end of it
module apb_slave_regfile #(
   parameter int          SLAVE_ID    = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input logic                Pclk,
   input logic                Preset,
   apb_slave_regfile_if.slave apb
);

   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [2:0] RO_IDX   = 3'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        pwrite_q;
   logic [2:0]  idx_q;
   logic        err_q;
   logic [31:0] prdata_q;
   logic [31:0] regs [NUM_REGS];

   logic        sel;
   logic        setup;
   logic        hit;
   logic [2:0]  idx;
   logic        ro;
   logic        err;
   logic        start;
   logic        load_rd;
   logic        commit;
   logic        unused_bits;

   assign sel     = apb.Pselx[SLAVE_ID];
   assign setup   = sel & ~apb.Penable;
   assign hit     = (apb.Paddr[31:5] == BASE_ADDR[31:5]);
   assign idx     = apb.Paddr[4:2];
   assign ro      = (idx == RO_IDX);
   assign err     = ~hit | (apb.Pwrite & ro);
   assign start   = (state == ST_IDLE) & setup;
   assign load_rd = start & ~apb.Pwrite & ~err;
   assign commit  = (state == ST_READY) & sel & apb.Penable & pwrite_q & ~err_q;

   // Byte-lane bits and foreign select bits are deliberately ignored.
   assign unused_bits = ^{apb.Paddr[1:0], apb.Pselx};

   assign apb.Prdata  = prdata_q;
   assign apb.Pready  = (state == ST_READY);
   assign apb.Pslverr = (state == ST_READY) & err_q;

   // Next-state and wait counter; aborts if select drops during the wait.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (setup) begin
               state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_READY;
               cnt_nxt   = CNT_INIT;
            end
         end
         ST_WAIT: begin
            if (!sel)
               state_nxt = ST_IDLE;
            else if (cnt == 4'd0)
               state_nxt = ST_READY;
            else
               cnt_nxt = cnt - 4'd1;
         end
         ST_READY: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register plus transfer bookkeeping, read data and register bank.
   always_ff @(posedge Pclk) begin
      if (Preset) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         pwrite_q <= 1'b0;
         idx_q    <= 3'd0;
         err_q    <= 1'b0;
         prdata_q <= 32'd0;
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= 32'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (start) begin
            pwrite_q <= apb.Pwrite;
            idx_q    <= idx;
            err_q    <= err;
         end
         if (load_rd)
            prdata_q <= ro ? ID_VALUE : regs[idx];
         if (commit)
            regs[idx_q] <= apb.Pwdata;
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: two responders (0 and 3 wait states) on separate buses.
module tb_apb_slave_regfile;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] IDV  = 32'hA9B0_0001;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tgt = 1'b0;
   logic [2:0]  pselx = 3'b000;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = 32'd0;
   logic [31:0] pwdata = 32'd0;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] rdata;
   logic        rerr;
   int          waits;

   apb_slave_regfile_if if0 ();
   apb_slave_regfile_if if3 ();

   assign if0.Pselx   = (tgt == 1'b0) ? pselx : 3'b000;
   assign if0.Penable = penable;
   assign if0.Pwrite  = pwrite;
   assign if0.Paddr   = paddr;
   assign if0.Pwdata  = pwdata;
   assign if3.Pselx   = (tgt == 1'b1) ? pselx : 3'b000;
   assign if3.Penable = penable;
   assign if3.Pwrite  = pwrite;
   assign if3.Paddr   = paddr;
   assign if3.Pwdata  = pwdata;

   apb_slave_regfile #(.SLAVE_ID(0), .BASE_ADDR(BASE), .NUM_REGS(8),
                       .WAIT_STATES(0), .ID_VALUE(IDV))
      dut0 (.Pclk(clk), .Preset(rst), .apb(if0.slave));

   apb_slave_regfile #(.SLAVE_ID(0), .BASE_ADDR(BASE), .NUM_REGS(8),
                       .WAIT_STATES(3), .ID_VALUE(IDV))
      dut3 (.Pclk(clk), .Preset(rst), .apb(if3.slave));

   always #5 clk = ~clk;

   function automatic logic [31:0] obs_rdata();
      return tgt ? if3.Prdata : if0.Prdata;
   endfunction

   function automatic logic obs_ready();
      return tgt ? if3.Pready : if0.Pready;
   endfunction

   function automatic logic obs_err();
      return tgt ? if3.Pslverr : if0.Pslverr;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transfer; returns data/error at the Pready cycle and the
   // number of Pready-low access cycles seen before it.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int nw);
      @(posedge clk); #1;
      pselx = 3'b001; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      nw = 0;
      while (!obs_ready() && nw < 40) begin
         @(posedge clk); #1;
         nw++;
      end
      rd = obs_rdata();
      er = obs_err();
      @(posedge clk); #1;
      pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
   endtask

   initial begin
      // Reset for two cycles
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b0;
      check("rst_prdata", if0.Prdata, 32'd0);
      check("rst_pready", 32'(if0.Pready), 32'd0);
      check("rst_pslverr", 32'(if0.Pslverr), 32'd0);
      tgt = 1'b0;
      xfer(1'b0, BASE + 32'h0, 32'd0, rdata, rerr, waits);
      check("rst_read0", rdata, 32'd0);

      // Zero-wait write then read
      xfer(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, rdata, rerr, waits);
      check("ws0_wr_waits", 32'(waits), 32'd0);
      check("ws0_wr_err", 32'(rerr), 32'd0);
      xfer(1'b0, BASE + 32'h8, 32'd0, rdata, rerr, waits);
      check("ws0_rd_waits", 32'(waits), 32'd0);
      check("ws0_rd_data", rdata, 32'hDEAD_BEEF);
      check("ws0_rd_err", 32'(rerr), 32'd0);

      // Address miss: error, read data held
      xfer(1'b0, BASE + 32'h40, 32'd0, rdata, rerr, waits);
      check("miss_err", 32'(rerr), 32'd1);
      check("miss_hold", rdata, 32'hDEAD_BEEF);

      // Foreign select bit: no response, no write
      @(posedge clk); #1;
      pselx = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h8; pwdata = 32'h77;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("foreign_pready", 32'(if0.Pready), 32'd0);
         @(posedge clk); #1;
      end
      pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
      xfer(1'b0, BASE + 32'h8, 32'd0, rdata, rerr, waits);
      check("foreign_nowrite", rdata, 32'hDEAD_BEEF);

      // Three wait states: ID register read
      tgt = 1'b1;
      xfer(1'b0, BASE + 32'h1C, 32'd0, rdata, rerr, waits);
      check("ws3_waits", 32'(waits), 32'd3);
      check("ws3_id", rdata, IDV);
      check("ws3_id_err", 32'(rerr), 32'd0);

      // Write to read-only ID register
      xfer(1'b1, BASE + 32'h1C, 32'h1, rdata, rerr, waits);
      check("ro_wr_err", 32'(rerr), 32'd1);
      xfer(1'b0, BASE + 32'h1C, 32'd0, rdata, rerr, waits);
      check("ro_readback", rdata, IDV);

      // Seed idx 2, then abort a write mid-wait
      xfer(1'b1, BASE + 32'h8, 32'h0000_1234, rdata, rerr, waits);
      check("seed_err", 32'(rerr), 32'd0);
      @(posedge clk); #1;
      pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h8; pwdata = 32'h55;
      @(posedge clk); #1;
      penable = 1'b1;
      check("abort_wait0", 32'(if3.Pready), 32'd0);
      @(posedge clk); #1;
      check("abort_wait1", 32'(if3.Pready), 32'd0);
      pselx = 3'b000; penable = 1'b0;
      @(posedge clk); #1;
      check("abort_idle", 32'(if3.Pready), 32'd0);
      xfer(1'b0, BASE + 32'h8, 32'd0, rdata, rerr, waits);
      check("abort_unchanged", rdata, 32'h0000_1234);

      // Reset pulsed mid-wait clears everything
      @(posedge clk); #1;
      pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h8; pwdata = 32'h55;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
      check("midrst_pready", 32'(if3.Pready), 32'd0);
      check("midrst_prdata", if3.Prdata, 32'd0);
      for (int i = 0; i < 7; i++) begin
         xfer(1'b0, BASE + 32'(i * 4), 32'd0, rdata, rerr, waits);
         check("midrst_reg_zero", rdata, 32'd0);
      end
      tgt = 1'b0;
      xfer(1'b0, BASE + 32'h8, 32'd0, rdata, rerr, waits);
      check("midrst_ws0_cleared", rdata, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
